// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: CPU/UART register offsets,
// LSR ready-bit index, master FSM encoding and the STATUS word layout.
package uart_tx_feeder_pkg;

    localparam logic [1:0] CPU_OFF_DATA   = 2'd0;
    localparam logic [1:0] CPU_OFF_STATUS = 2'd1;
    localparam logic [1:0] CPU_OFF_CTRL   = 2'd2;

    localparam logic [1:0] OFF_UART_DATA  = 2'd0;
    localparam logic [1:0] OFF_UART_LSR   = 2'd1;

    localparam int LSR_TS_BIT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POLL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_GUARD = 2'd3
    } txf_state_t;

    function automatic logic [31:0] status_word(input logic [7:0] wmark,
                                                input logic [7:0] count,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        return {wmark, 8'h00, count, 5'b0, ovf, full, empty};
    endfunction

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// txf_fifo: byte FIFO, registered pointers, combinational head/count; 1-cycle push-to-visible.
// Pushes while full are dropped here (caller tracks overflow); flush clears pointers and beats a push.
module txf_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [7:0]            i_dat,
    output logic [7:0]            o_head,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [7:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_push;
    logic                w_pop;

    // Extra pointer bit distinguishes full from empty; count never exceeds DEPTH
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = o_count[DEPTH_LOG2];
    assign o_empty = (o_count == '0);
    assign o_head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_dat;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: CPU byte FIFO drained into MiniUART by polling LSR.ts then writing DATA (push->WRITE 2 cycles).
// CPU pushes never stall (overflow drops + sticky ovf); optional UART_TXF_IRQ_EN adds watermark and TXF_IntReq.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [3:2]  ADD_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic [3:2]  U_ADD_O,
    output logic [31:0] U_DAT_O,
    input  logic [31:0] U_DAT_I,
    output logic        U_STB_O,
    output logic        U_WE_O
`ifdef UART_TXF_IRQ_EN
    ,
    output logic        TXF_IntReq
`endif
);

    txf_state_t          r_state;
    txf_state_t          w_next_state;
    logic [3:0]          r_guard_cnt;
    logic                r_ovf;
    logic [7:0]          w_wmark;
    logic                w_cpu_wr;
    logic                w_push_req;
    logic                w_ctrl_wr;
    logic                w_flush;
    logic                w_ovf_clr;
    logic                w_ts;
    logic [7:0]          w_head;
    logic [DEPTH_LOG2:0] w_count;
    logic [7:0]          w_count8;
    logic                w_full;
    logic                w_empty;
    logic                w_unused;

    assign w_cpu_wr   = STB_I & WE_I;
    assign w_push_req = w_cpu_wr & (ADD_I == CPU_OFF_DATA);
    assign w_ctrl_wr  = w_cpu_wr & (ADD_I == CPU_OFF_CTRL);
    assign w_flush    = w_ctrl_wr & DAT_I[0];
    assign w_ovf_clr  = w_ctrl_wr & DAT_I[1];
    assign w_ts       = U_DAT_I[LSR_TS_BIT];
    assign w_count8   = 8'(w_count);

    txf_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (CLK_I),
        .i_rst   (RST_I),
        .i_push  (w_push_req),
        .i_pop   (r_state == ST_WRITE),
        .i_flush (w_flush),
        .i_dat   (DAT_I[7:0]),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A flushed push is discarded, so it cannot count as an overflow either
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_ovf <= 1'b0;
        end else if (w_push_req && w_full && !w_flush) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I || r_state != ST_GUARD) begin
            r_guard_cnt <= 4'd0;
        end else begin
            r_guard_cnt <= r_guard_cnt + 4'd1;
        end
    end

    // WRITE always runs to GUARD: its byte is already on the UART bus
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty && !w_flush) w_next_state = ST_POLL;
            ST_POLL: begin
                if (w_flush || w_empty) w_next_state = ST_IDLE;
                else if (w_ts)          w_next_state = ST_WRITE;
            end
            ST_WRITE: w_next_state = ST_GUARD;
            ST_GUARD: begin
                if (w_flush || r_guard_cnt == 4'(GUARD_CYCLES - 1)) w_next_state = ST_IDLE;
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        U_ADD_O = OFF_UART_DATA;
        U_DAT_O = 32'h0;
        U_STB_O = 1'b0;
        U_WE_O  = 1'b0;
        case (r_state)
            ST_POLL: begin
                U_ADD_O = OFF_UART_LSR;
                U_STB_O = 1'b1;
            end
            ST_WRITE: begin
                U_ADD_O = OFF_UART_DATA;
                U_DAT_O = {24'h0, w_head};
                U_STB_O = 1'b1;
                U_WE_O  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        DAT_O = 32'h0;
        if (ADD_I == CPU_OFF_STATUS) begin
            DAT_O = status_word(w_wmark, w_count8, r_ovf, w_full, w_empty);
        end
    end

`ifdef UART_TXF_IRQ_EN
    logic [7:0] r_wmark;
    logic       r_irq;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_wmark <= 8'h0;
            r_irq   <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_wmark <= DAT_I[11:4];
            r_irq <= (9'(w_count) <= {1'b0, r_wmark}) && (r_state == ST_IDLE);
        end
    end

    assign w_wmark    = r_wmark;
    assign TXF_IntReq = r_irq;
    assign w_unused   = ^{DAT_I[31:12], U_DAT_I[31:6], U_DAT_I[4:0]};
`else
    assign w_wmark    = 8'h0;
    assign w_unused   = ^{DAT_I[31:8], U_DAT_I[31:6], U_DAT_I[4:0]};
`endif

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Transmit-side byte buffer sitting between the CPU bus and the MiniUART slave.
- The CPU pushes bytes into a FIFO with single bus writes.
- The feeder acts as a bus master toward MiniUART:
  - polls its LSR until the transmitter is ready (ts, bit 5);
  - then writes the head byte to the MiniUART DATA register.
- Removes CPU busy-waiting on ts for multi-byte messages.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries); legal range 1..8.
GUARD_CYCLES, 2, idle cycles after each UART write before polling LSR again, so MiniUART load/ts settle; legal range 1..15.

Ports:
CLK_I  in  1  clock; single clock domain.
RST_I  in  1  synchronous, active-high reset.
ADD_I  in  2 ([3:2])  CPU-side register select.
DAT_I  in  32  CPU write data.
DAT_O  out  32  CPU read data, combinational from ADD_I.
STB_I  in  1  CPU strobe.
WE_I  in  1  CPU write enable.
U_ADD_O  out  2 ([3:2])  address toward MiniUART.
U_DAT_O  out  32  write data toward MiniUART.
U_DAT_I  in  32  MiniUART read data (combinational on its side).
U_STB_O  out  1  strobe toward MiniUART.
U_WE_O  out  1  write enable toward MiniUART.
TXF_IntReq  out  1  low-watermark interrupt; present only with the optional feature.

Behaviour:
CPU register map (ADD_I):
- 0 DATA (write only): push DAT_I[7:0].
- 1 STATUS (read): {16'b0, count[7:0], 5'b0, ovf, full, empty}.
- 2 CTRL (write): bit0 = flush, bit1 = clear ovf.
- 3: reads 0, writes ignored.

FIFO:
- Push when STB_I & WE_I & ADD_I==0 and not full.
- Push while full: data dropped, ovf set (sticky).
- Pop only in state WRITE.
- Push and pop in the same cycle are both honoured; count unchanged.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally.
- full = count==2^DEPTH_LOG2; empty = count==0.

Flush:
- Clears pointers and count next edge; ovf unaffected.
- Flush concurrent with a DATA push: flush wins, the pushed byte is discarded.
- FSM not in WRITE moves to IDLE.
- A WRITE in progress completes (its byte is already committed) and proceeds to GUARD.

Master FSM (registered state):
- IDLE: all U_* outputs 0. If !empty, go to POLL.
- POLL:
  - Drives U_ADD_O=1 (LSR), U_STB_O=1, U_WE_O=0; samples U_DAT_I[5] in the same cycle.
  - ts=1: go to WRITE.
  - ts=0: stay in POLL.
  - empty (after flush): go to IDLE.
- WRITE: exactly one cycle.
  - Drives U_ADD_O=0 (DATA), U_STB_O=1, U_WE_O=1, U_DAT_O={24'b0, head}.
  - Pops the FIFO; go to GUARD.
- GUARD: U_* outputs 0; counter runs GUARD_CYCLES cycles, then go to IDLE.

Outputs:
- U_DAT_O is 0 outside WRITE.
- U_* outputs are decoded from the registered state.

Latency: byte pushed at edge n into an empty FIFO, UART ready → POLL in cycle n+1, WRITE in cycle n+2.

Reset: state IDLE, pointers/count 0, ovf 0, guard counter 0, all U_* outputs 0, TXF_IntReq 0. Reset applied mid-WRITE aborts the write at that edge.

Optional Feature:
UART_TXF_IRQ_EN
- Defined:
  - CTRL bits[11:4] hold a watermark, reset 0.
  - TXF_IntReq is a registered level: 1 when count <= watermark and the FSM is IDLE; it updates one cycle after the condition.
  - STATUS bits[31:24] read back the watermark.
- Not defined: the port is absent, CTRL bits[11:4] are ignored, and STATUS[31:24] reads 0.

Decomposition:
- Shared package/header: CPU offsets (DATA=0, STATUS=1, CTRL=2), UART offsets (OFF_UART_DATA=0, OFF_UART_LSR=1), LSR ts bit index 5, FSM state encoding (IDLE/POLL/WRITE/GUARD, 2 bits).
- One sub-module: txf_fifo (synchronous FIFO with push, pop, flush, count, full, empty), parameterised by DEPTH_LOG2.

Test Plan:
1. Push 0x41 with UART ts=1 → POLL next cycle, then one WRITE cycle with U_DAT_O=0x00000041, U_WE_O=1. Then GUARD for 2 cycles, then IDLE; STATUS empty=1.
2. Push 3 bytes with ts held 0 for 20 cycles → FSM stays in POLL and STATUS count=3. Once ts=1, three WRITEs are issued in order, separated by ≥GUARD_CYCLES+2 cycles.
3. Push 17 bytes with ts=0 → full=1, ovf=1, count=16. Write CTRL=2 → ovf=0, and data is unchanged.
4. Push and pop on the same edge at count=5 → count stays 5, and the byte order is preserved across pointer wrap after 40 bytes.
5. Flush while in POLL with count=4 → IDLE next cycle, empty=1, and no U_WE_O pulse appears.
6. Assert RST_I during WRITE → next cycle all U_* outputs are 0, count=0, FSM IDLE. With UART_TXF_IRQ_EN and watermark=2, draining from 4 raises TXF_IntReq when count reaches 2 in IDLE.
